// File: rtl/pipe_ctrl.sv
// Pipelined MIPS control unit: ID decode carried through ID/EX, EX/MEM, MEM/WB,
// with branch/jump flush; load-use stall insertion is built only when PIPE_CTRL_HAZARD_EN is defined.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       flush,
  output logic [1:0] Jmp,
  output logic       stall,
  output logic [1:0] RegDst,
  output logic       AluSrc,
  output logic       AluSrc1,
  output logic [3:0] AluOperation,
  output logic       Branch,
  output logic       not_equal_Branch,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       DataC
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src;
    logic       alu_src1;
    logic [3:0] alu_op;
  } ex_ctl_t;

  typedef struct packed {
    logic branch;
    logic bne;
    logic mem_read;
    logic mem_write;
  } mem_ctl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic data_c;
  } wb_ctl_t;

  typedef struct packed {
    ex_ctl_t  ex;
    mem_ctl_t mem;
    wb_ctl_t  wb;
  } id_ex_t;

  typedef struct packed {
    mem_ctl_t mem;
    wb_ctl_t  wb;
  } ex_mem_t;

  id_ex_t     dec_d;
  logic [1:0] dec_jmp;
  logic       r_ok;
  logic [3:0] r_alu;

  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  wb_ctl_t mem_wb_q, mem_wb_d;

  logic stall_int;
  logic bubble;

  always_comb begin
    dec_d   = '0;
    dec_jmp = 2'b00;
    r_ok    = 1'b1;
    r_alu   = ALU_ADD;
    case (func)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      FN_SLL:  r_alu = ALU_SLL;
      default: r_ok  = 1'b0;
    endcase
    case (opcode)
      OP_RTYPE: begin
        if (func == FN_JR) begin
          dec_jmp = 2'b10;
        end else if (r_ok) begin
          dec_d.ex.reg_dst   = DST_RD;
          dec_d.ex.alu_op    = r_alu;
          dec_d.ex.alu_src1  = (func == FN_SLL);
          dec_d.wb.reg_write = 1'b1;
        end
      end
      OP_ADDI, OP_SLTI: begin
        dec_d.ex.alu_src   = 1'b1;
        dec_d.ex.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        dec_d.wb.reg_write = 1'b1;
      end
      OP_LW: begin
        dec_d.ex.alu_src    = 1'b1;
        dec_d.ex.alu_op     = ALU_ADD;
        dec_d.mem.mem_read  = 1'b1;
        dec_d.wb.mem_to_reg = 1'b1;
        dec_d.wb.reg_write  = 1'b1;
      end
      OP_SW: begin
        dec_d.ex.alu_src    = 1'b1;
        dec_d.ex.alu_op     = ALU_ADD;
        dec_d.mem.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_d.ex.alu_op  = ALU_SUB;
        dec_d.mem.branch = 1'b1;
      end
      OP_BNE: begin
        dec_d.ex.alu_op = ALU_SUB;
        dec_d.mem.bne   = 1'b1;
      end
      OP_J: begin
        dec_jmp = 2'b01;
      end
      OP_JAL: begin
        dec_jmp            = 2'b01;
        dec_d.ex.reg_dst   = DST_R31;
        dec_d.wb.reg_write = 1'b1;
        dec_d.wb.data_c    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPE_CTRL_HAZARD_EN
  logic [4:0] ex_dest_q, ex_dest_d;
  logic       hazard;

  always_comb begin
    case (dec_d.ex.reg_dst)
      DST_RD:  ex_dest_d = id_rd;
      DST_R31: ex_dest_d = 5'd31;
      default: ex_dest_d = id_rt;
    endcase
  end

  // Only a load sitting in EX can produce data too late for the instruction in ID.
  assign hazard = id_ex_q.mem.mem_read && (ex_dest_q != 5'd0) &&
                  ((ex_dest_q == id_rs) || (ex_dest_q == id_rt));
  assign stall_int = hazard & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_dest_q <= '0;
    end else if (bubble) begin
      ex_dest_q <= '0;
    end else begin
      ex_dest_q <= ex_dest_d;
    end
  end
`else
  logic unused_id_regs;
  assign unused_id_regs = ^{id_rs, id_rt, id_rd};
  assign stall_int = 1'b0;
`endif

  assign bubble   = flush | stall_int;
  assign id_ex_d  = bubble ? '0 : dec_d;
  assign ex_mem_d = flush ? '0 : {id_ex_q.mem, id_ex_q.wb};
  assign mem_wb_d = ex_mem_q.wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign Jmp              = bubble ? 2'b00 : dec_jmp;
  assign stall            = stall_int;
  assign RegDst           = id_ex_q.ex.reg_dst;
  assign AluSrc           = id_ex_q.ex.alu_src;
  assign AluSrc1          = id_ex_q.ex.alu_src1;
  assign AluOperation     = id_ex_q.ex.alu_op;
  assign Branch           = ex_mem_q.mem.branch;
  assign not_equal_Branch = ex_mem_q.mem.bne;
  assign MemRead          = ex_mem_q.mem.mem_read;
  assign MemWrite         = ex_mem_q.mem.mem_write;
  assign RegWrite         = mem_wb_q.reg_write;
  assign MemtoReg         = mem_wb_q.mem_to_reg;
  assign DataC            = mem_wb_q.data_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// instruction streams compared against a stage-by-stage reference model.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;
  logic [1:0] Jmp;
  logic       stall;
  logic [1:0] RegDst;
  logic       AluSrc, AluSrc1;
  logic [3:0] AluOperation;
  logic       Branch, not_equal_Branch, MemRead, MemWrite;
  logic       RegWrite, MemtoReg, DataC;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_CTRL_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .Jmp(Jmp), .stall(stall), .RegDst(RegDst), .AluSrc(AluSrc),
    .AluSrc1(AluSrc1), .AluOperation(AluOperation), .Branch(Branch),
    .not_equal_Branch(not_equal_Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .DataC(DataC)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_vec;
  assign dut_vec = {Jmp, stall, RegDst, AluSrc, AluSrc1, AluOperation, Branch,
                    not_equal_Branch, MemRead, MemWrite, RegWrite, MemtoReg, DataC};

  localparam logic [5:0] NOP_OP = 6'b111111;

  typedef struct packed {
    logic [1:0] jmp;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic       alu_src1;
    logic [3:0] alu_op;
    logic       branch;
    logic       bne;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       data_c;
  } ctl_t;

  // Straight transcription of the instruction control table.
  function automatic ctl_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: begin c.reg_dst = 2'b01; c.reg_write = 1; c.alu_op = 4'b0010; end
          6'b100010: begin c.reg_dst = 2'b01; c.reg_write = 1; c.alu_op = 4'b0110; end
          6'b100100: begin c.reg_dst = 2'b01; c.reg_write = 1; c.alu_op = 4'b0000; end
          6'b100101: begin c.reg_dst = 2'b01; c.reg_write = 1; c.alu_op = 4'b0001; end
          6'b101010: begin c.reg_dst = 2'b01; c.reg_write = 1; c.alu_op = 4'b0111; end
          6'b000000: begin c.reg_dst = 2'b01; c.reg_write = 1; c.alu_op = 4'b1000; c.alu_src1 = 1; end
          6'b001000: c.jmp = 2'b10;
          default: ;
        endcase
      end
      6'b001000: begin c.alu_src = 1; c.reg_write = 1; c.alu_op = 4'b0010; end
      6'b001010: begin c.alu_src = 1; c.reg_write = 1; c.alu_op = 4'b0111; end
      6'b100011: begin c.alu_src = 1; c.mem_read = 1; c.mem_to_reg = 1; c.reg_write = 1; c.alu_op = 4'b0010; end
      6'b101011: begin c.alu_src = 1; c.mem_write = 1; c.alu_op = 4'b0010; end
      6'b000100: begin c.branch = 1; c.alu_op = 4'b0110; end
      6'b000101: begin c.bne = 1; c.alu_op = 4'b0110; end
      6'b000010: c.jmp = 2'b01;
      6'b000011: begin c.jmp = 2'b01; c.reg_dst = 2'b10; c.reg_write = 1; c.data_c = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic fl);
    opcode = op; func = fn; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(6'b100011, 6'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (dut_vec !== 18'h0) begin errors++; $display("FAIL reset_clear got %h want 0", dut_vec); end
    tick();
    checks++;
    if (dut_vec !== 18'h0) begin errors++; $display("FAIL reset_hold got %h want 0", dut_vec); end
    rst = 1'b0;
    tick();
    checks++;
    if ({AluSrc, MemRead, RegDst, AluOperation} !== {1'b1, 1'b0, 2'b00, 4'b0010}) begin
      errors++; $display("FAIL reset_rel_ex got %b want 1000010", {AluSrc, MemRead, RegDst, AluOperation});
    end
    drive(NOP_OP, 6'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if ({AluSrc, MemRead, RegWrite} !== 3'b010) begin
      errors++; $display("FAIL reset_rel_mem got %b want 010", {AluSrc, MemRead, RegWrite});
    end
    tick();
    checks++;
    if ({MemRead, MemtoReg, RegWrite} !== 3'b011) begin
      errors++; $display("FAIL reset_rel_wb got %b want 011", {MemRead, MemtoReg, RegWrite});
    end
    $display("test_reset done");
  endtask

  task automatic test_rtype();
    drive(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 1'b0);
    #1;
    checks++;
    if ({Jmp, stall} !== 3'b000) begin errors++; $display("FAIL add_comb got %b want 000", {Jmp, stall}); end
    tick();
    checks++;
    if ({RegDst, AluOperation, AluSrc, AluSrc1} !== {2'b01, 4'b0010, 2'b00}) begin
      errors++; $display("FAIL add_ex got %b want 01001000", {RegDst, AluOperation, AluSrc, AluSrc1});
    end
    drive(6'b000000, 6'b000000, 5'd0, 5'd4, 5'd5, 1'b0);
    tick();
    checks++;
    if ({AluSrc1, AluOperation, RegDst} !== {1'b1, 4'b1000, 2'b01}) begin
      errors++; $display("FAIL sll_ex got %b want 1100001", {AluSrc1, AluOperation, RegDst});
    end
    drive(NOP_OP, 6'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if ({RegWrite, MemtoReg, DataC} !== 3'b100) begin
      errors++; $display("FAIL add_wb got %b want 100", {RegWrite, MemtoReg, DataC});
    end
    $display("test_rtype done");
  endtask

  task automatic test_jumps();
    drive(6'b000000, 6'b001000, 5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (Jmp !== 2'b10) begin errors++; $display("FAIL jr_jmp got %b want 10", Jmp); end
    tick();
    checks++;
    if ({RegDst, AluSrc, AluSrc1, AluOperation} !== 8'h0) begin
      errors++; $display("FAIL jr_ex got %b want 0", {RegDst, AluSrc, AluSrc1, AluOperation});
    end
    drive(6'b000011, 6'b010101, 5'd3, 5'd3, 5'd3, 1'b0);
    #1;
    checks++;
    if (Jmp !== 2'b01) begin errors++; $display("FAIL jal_jmp got %b want 01", Jmp); end
    tick();
    checks++;
    if (RegDst !== 2'b10) begin errors++; $display("FAIL jal_ex got %b want 10", RegDst); end
    drive(NOP_OP, 6'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    checks++;
    if ({DataC, RegWrite, MemtoReg} !== 3'b110) begin
      errors++; $display("FAIL jal_wb got %b want 110", {DataC, RegWrite, MemtoReg});
    end
    $display("test_jumps done");
  endtask

  task automatic test_load_use();
    drive(6'b100011, 6'b0, 5'd1, 5'd5, 5'd0, 1'b0);
    tick();
    drive(6'b000000, 6'b100000, 5'd5, 5'd2, 5'd6, 1'b0);
    #1;
    checks++;
    if ({stall, Jmp} !== {HZ, 2'b00}) begin
      errors++; $display("FAIL lu_stall got %b want %b00", {stall, Jmp}, HZ);
    end
    tick();
    checks++;
    if ({RegDst, AluOperation, MemRead} !== (HZ ? 7'b0000001 : 7'b0100101)) begin
      errors++; $display("FAIL lu_bubble got %b want %b", {RegDst, AluOperation, MemRead},
                         (HZ ? 7'b0000001 : 7'b0100101));
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %b want 0", stall); end
    tick();
    checks++;
    if ({RegDst, AluOperation} !== 6'b010010) begin
      errors++; $display("FAIL lu_resume got %b want 010010", {RegDst, AluOperation});
    end
    // Hazard through rt while a jump sits in ID: the jump must be held back.
    drive(6'b100011, 6'b0, 5'd0, 5'd4, 5'd0, 1'b0);
    tick();
    drive(6'b000010, 6'b0, 5'd3, 5'd4, 5'd0, 1'b0);
    #1;
    checks++;
    if ({stall, Jmp} !== (HZ ? 3'b100 : 3'b001)) begin
      errors++; $display("FAIL lu_rt_jmp got %b want %b", {stall, Jmp}, (HZ ? 3'b100 : 3'b001));
    end
    tick();
    drive(6'b100011, 6'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(6'b000000, 6'b100000, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_r0 got %b want 0", stall); end
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_flush();
    drive(6'b000100, 6'b0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(6'b100011, 6'b0, 5'd0, 5'd4, 5'd0, 1'b0);
    tick();
    drive(6'b000010, 6'b0, 5'd4, 5'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if ({stall, Jmp, Branch} !== 4'b0001) begin
      errors++; $display("FAIL flush_comb got %b want 0001", {stall, Jmp, Branch});
    end
    tick();
    checks++;
    if (dut_vec[14:0] !== 15'h0) begin
      errors++; $display("FAIL flush_clear got %h want 0", dut_vec[14:0]);
    end
    drive(6'b001000, 6'b0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(6'b100011, 6'b0, 5'd0, 5'd4, 5'd0, 1'b0);
    tick();
    drive(NOP_OP, 6'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    checks++;
    if ({RegWrite, MemtoReg, MemRead, AluSrc} !== 4'b1000) begin
      errors++; $display("FAIL flush_wb_adv got %b want 1000", {RegWrite, MemtoReg, MemRead, AluSrc});
    end
    drive(NOP_OP, 6'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    drive(6'b100011, 6'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    tick();
    checks++;
    if ({AluSrc, MemRead, RegWrite} !== 3'b111) begin
      errors++; $display("FAIL async_pre got %b want 111", {AluSrc, MemRead, RegWrite});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 18'h0) begin errors++; $display("FAIL async_clear got %h want 0", dut_vec); end
    drive(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if ({RegDst, AluOperation, MemRead, RegWrite} !== 8'b01001000) begin
      errors++; $display("FAIL async_first got %b want 01001000", {RegDst, AluOperation, MemRead, RegWrite});
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    logic [5:0] fns [7];
    ctl_t m_ex, m_mem, m_wb, d;
    logic [4:0] m_dest;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic fl, hz, e_stall;
    logic [1:0] e_jmp;
    logic [17:0] exp_vec;
    int idx;
    ops = '{6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011,
            6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b100011};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b001000};
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_ex = '0; m_mem = '0; m_wb = '0; m_dest = '0;
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 10);
      op = (idx == 10) ? 6'($urandom) : ops[idx];
      idx = $urandom_range(0, 7);
      fn = (idx == 7) ? 6'($urandom) : fns[idx];
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      fl = ($urandom_range(0, 7) == 0);
      drive(op, fn, rs, rt, rd, fl);
      #1;
      d = ref_decode(op, fn);
      hz = HZ && m_ex.mem_read && (m_dest != 5'd0) && ((m_dest == rs) || (m_dest == rt));
      e_stall = hz && !fl;
      e_jmp = (fl || e_stall) ? 2'b00 : d.jmp;
      exp_vec = {e_jmp, e_stall, m_ex.reg_dst, m_ex.alu_src, m_ex.alu_src1, m_ex.alu_op,
                 m_mem.branch, m_mem.bne, m_mem.mem_read, m_mem.mem_write,
                 m_wb.reg_write, m_wb.mem_to_reg, m_wb.data_c};
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL rand_%0d got %b want %b", n, dut_vec, exp_vec);
      end
      $display("rand %0d op=%b fn=%b rs=%0d rt=%0d rd=%0d fl=%b out=%b", n, op, fn, rs, rt, rd, fl, dut_vec);
      @(posedge clk);
      m_wb  = m_mem;
      m_mem = fl ? '0 : m_ex;
      if (fl || e_stall) begin
        m_ex = '0;
        m_dest = 5'd0;
      end else begin
        m_ex = d;
        m_dest = (d.reg_dst == 2'b01) ? rd : (d.reg_dst == 2'b10) ? 5'd31 : rt;
      end
      #1;
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    drive(NOP_OP, 6'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    test_reset();
    test_rtype();
    test_jumps();
    test_load_use();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
